// File: rtl/vin_gearbox_fifo.sv
// Packs CH_COUNT x PIX_W pixel strobes LSB-first into OUT_W words, tagged SOF/EOL, buffered in a FWFT FIFO.
// Words wait one cycle in a write register for the EOL decision; no backpressure, writes to a full FIFO drop and set ovf.
module vin_gearbox_fifo #(
   parameter int CH_COUNT = 10,
   parameter int PIX_W    = 8,
   parameter int OUT_W    = 128,
   parameter int DEPTH    = 16
) (
   input  logic                          p_in_clk,
   input  logic                          p_in_rst_n,
   input  logic [CH_COUNT*PIX_W-1:0]     p_in_vd,
   input  logic                          p_in_vin_hs,
   input  logic                          p_in_vin_vs,
   input  logic [1:0]                    p_in_mode,
   input  logic                          p_in_rd,
   input  logic                          p_in_ovf_clr,
   output logic [OUT_W-1:0]              p_out_d,
   output logic                          p_out_sof,
   output logic                          p_out_eol,
   output logic                          p_out_den,
   output logic [$clog2(DEPTH):0]        p_out_fifo_cnt,
   output logic                          p_out_ovf
);
   localparam int IN_W  = CH_COUNT * PIX_W;
   localparam int ACC_W = OUT_W + IN_W;
   localparam int FW    = $clog2(ACC_W + 1);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;

   typedef enum logic [1:0] {
      MODE_VIDEO    = 2'b00,
      MODE_RAMP     = 2'b01,
      MODE_DROP     = 2'b10,
      MODE_DROP_ALT = 2'b11
   } mode_e;

   typedef struct packed {
      logic             eol;
      logic             sof;
      logic [OUT_W-1:0] dat;
   } word_t;

   mode_e            mode_q;
   logic             vs_d, hs_d, sof_pend;
   logic [PIX_W-1:0] pix_cnt;
   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [FW-1:0]    fill_q, fill_d, fill_sum;
   logic [IN_W-1:0]  ramp, din;
   logic             word_vld, word_eol, eol_fix;
   logic [OUT_W-1:0] word_dat;
   word_t            wreg;
   logic             wreg_vld;

   logic             vs_rise, hs_fall, drop;
   assign vs_rise = p_in_vin_vs & ~vs_d;
   assign hs_fall = hs_d & ~p_in_vin_hs;
   assign drop    = (mode_q == MODE_DROP) || (mode_q == MODE_DROP_ALT);

   for (genvar c = 0; c < CH_COUNT; c++) begin : g_ramp
      assign ramp[c*PIX_W +: PIX_W] = pix_cnt + PIX_W'(c);
   end

   assign din      = (mode_q == MODE_RAMP) ? ramp : p_in_vd;
   assign acc_sum  = acc_q | (ACC_W'(din) << fill_q);
   assign fill_sum = fill_q + FW'(IN_W);

   always_comb begin
      acc_d    = acc_q;
      fill_d   = fill_q;
      word_vld = 1'b0;
      word_eol = 1'b0;
      word_dat = '0;
      eol_fix  = 1'b0;
      if (vs_rise) begin
         acc_d  = '0;
         fill_d = '0;
      end else if (!drop) begin
         if (p_in_vin_hs) begin
            if (fill_sum >= FW'(OUT_W)) begin
               word_vld = 1'b1;
               word_dat = acc_sum[OUT_W-1:0];
               acc_d    = acc_sum >> OUT_W;
               fill_d   = fill_sum - FW'(OUT_W);
            end else begin
               acc_d  = acc_sum;
               fill_d = fill_sum;
            end
         end else if (hs_d) begin
            // Bits above fill are always zero, so the partial word is already padded.
            if (fill_q != '0) begin
               word_vld = 1'b1;
               word_eol = 1'b1;
               word_dat = acc_q[OUT_W-1:0];
               acc_d    = '0;
               fill_d   = '0;
            end else begin
               eol_fix = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge p_in_clk) begin
      if (!p_in_rst_n) begin
         vs_d     <= 1'b0;
         hs_d     <= 1'b0;
         mode_q   <= MODE_VIDEO;
         sof_pend <= 1'b0;
         pix_cnt  <= '0;
         acc_q    <= '0;
         fill_q   <= '0;
         wreg     <= '0;
         wreg_vld <= 1'b0;
      end else begin
         vs_d     <= p_in_vin_vs;
         hs_d     <= p_in_vin_hs;
         acc_q    <= acc_d;
         fill_q   <= fill_d;
         wreg_vld <= word_vld;
         wreg     <= '{eol: word_eol, sof: sof_pend, dat: word_dat};
         if (vs_rise)
            mode_q <= mode_e'(p_in_mode);
         if (vs_rise)
            sof_pend <= 1'b1;
         else if (word_vld)
            sof_pend <= 1'b0;
         if (vs_rise || hs_fall || drop)
            pix_cnt <= '0;
         else if (p_in_vin_hs)
            pix_cnt <= pix_cnt + PIX_W'(1);
      end
   end

   word_t            mem [DEPTH];
   word_t            head, wr_word;
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    cnt_q;
   logic             ovf_q, full, pop, push;

   assign full    = (cnt_q == CW'(DEPTH));
   assign pop     = p_in_rd & (cnt_q != '0);
   // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
   assign push    = wreg_vld & (~full | pop);
   assign wr_word = '{eol: wreg.eol | eol_fix, sof: wreg.sof, dat: wreg.dat};

   always_ff @(posedge p_in_clk) begin
      if (push)
         mem[wr_ptr] <= wr_word;
   end

   always_ff @(posedge p_in_clk) begin
      if (!p_in_rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
         if (wreg_vld && !push)
            ovf_q <= 1'b1;
         else if (p_in_ovf_clr)
            ovf_q <= 1'b0;
      end
   end

   assign head           = mem[rd_ptr];
   assign p_out_den      = (cnt_q != '0);
   assign p_out_d        = p_out_den ? head.dat : '0;
   assign p_out_sof      = p_out_den & head.sof;
   assign p_out_eol      = p_out_den & head.eol;
   assign p_out_fifo_cnt = cnt_q;
   assign p_out_ovf      = ovf_q;

endmodule

// File: tb/tb_vin_gearbox_fifo.sv
// Bench for vin_gearbox_fifo: directed and random lines checked against a bit-stream reference model.
module tb_vin_gearbox_fifo;
   localparam int CH    = 10;
   localparam int PW    = 8;
   localparam int IN_W  = CH * PW;
   localparam int OUT_W = 128;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [IN_W-1:0]   vd = '0;
   logic              hs = 1'b0, vs = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic              rd = 1'b0, ovf_clr = 1'b0;
   logic [OUT_W-1:0]  dout;
   logic              sof, eol, den, ovf;
   logic [4:0]        cnt;

   vin_gearbox_fifo #(.CH_COUNT(CH), .PIX_W(PW), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .p_in_clk(clk), .p_in_rst_n(rst_n), .p_in_vd(vd), .p_in_vin_hs(hs), .p_in_vin_vs(vs),
      .p_in_mode(mode), .p_in_rd(rd), .p_in_ovf_clr(ovf_clr),
      .p_out_d(dout), .p_out_sof(sof), .p_out_eol(eol), .p_out_den(den),
      .p_out_fifo_cnt(cnt), .p_out_ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0] d;
      bit               sof;
      bit               eol;
   } wexp_t;

   wexp_t      exp_q[$];
   bit         bq[$];
   bit         m_vs_prev, m_hs_prev, m_sof_pend;
   logic [1:0] m_mode;
   int         m_pix;
   int         rd_pct;
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [IN_W-1:0] rnd();
      return IN_W'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic push_word(input logic [OUT_W-1:0] w, input bit e);
      exp_q.push_back('{d: w, sof: m_sof_pend, eol: e});
      m_sof_pend = 1'b0;
   endtask

   // Reference: the line is a bit stream, cut into OUT_W chunks; the tail is zero-padded at line end.
   task automatic model_cycle();
      logic [IN_W-1:0]  din;
      logic [OUT_W-1:0] w;
      wexp_t            t;
      int               n;
      if (!rst_n) begin
         exp_q.delete(); bq.delete();
         m_sof_pend = 0; m_mode = 2'b00; m_pix = 0; m_vs_prev = 0; m_hs_prev = 0;
         return;
      end
      if (vs && !m_vs_prev) begin
         bq.delete(); m_pix = 0; m_sof_pend = 1; m_mode = mode;
      end else if (!m_mode[1]) begin
         if (hs) begin
            din = vd;
            if (m_mode == 2'b01)
               for (int c = 0; c < CH; c++) din[c*PW +: PW] = PW'(m_pix + c);
            for (int i = 0; i < IN_W; i++) bq.push_back(din[i]);
            m_pix++;
            if (bq.size() >= OUT_W) begin
               for (int i = 0; i < OUT_W; i++) w[i] = bq.pop_front();
               push_word(w, 1'b0);
            end
         end else if (m_hs_prev) begin
            if (bq.size() > 0) begin
               w = '0; n = bq.size();
               for (int i = 0; i < n; i++) w[i] = bq.pop_front();
               push_word(w, 1'b1);
            end else if (exp_q.size() > 0) begin
               t = exp_q.pop_back(); t.eol = 1'b1; exp_q.push_back(t);
            end
         end
      end
      if (!hs || m_mode[1]) m_pix = 0;
      m_vs_prev = vs; m_hs_prev = hs;
   endtask

   // Called at a falling edge: decide rd, score any pop, drive inputs, advance one cycle.
   task automatic step(input bit h, input bit v, input logic [IN_W-1:0] data);
      wexp_t e;
      rd = ($urandom_range(99) < rd_pct);
      if (rd && den) begin
         check("exp_avail", OUT_W'(exp_q.size() > 0), OUT_W'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pop_d", dout, e.d);
            check("pop_sof", OUT_W'(sof), OUT_W'(e.sof));
            check("pop_eol", OUT_W'(eol), OUT_W'(e.eol));
         end
      end
      hs = h; vs = v; vd = data;
      model_cycle();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, '0);
   endtask

   task automatic vs_pulse(input logic [1:0] m);
      mode = m;
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
   endtask

   task automatic line(input int n);
      repeat (n) step(1'b1, 1'b0, rnd());
      step(1'b0, 1'b0, '0);
   endtask

   task automatic drain(input string tag);
      rd_pct = 100;
      idle(20);
      check({tag, "_den"}, OUT_W'(den), OUT_W'(0));
      check({tag, "_left"}, OUT_W'(exp_q.size()), OUT_W'(0));
   endtask

   initial begin
      rd_pct = 0;
      @(negedge clk);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      rst_n = 1'b1;
      check("rst_den", OUT_W'(den), OUT_W'(0));
      check("rst_cnt", OUT_W'(cnt), OUT_W'(0));
      check("rst_ovf", OUT_W'(ovf), OUT_W'(0));
      check("rst_d", dout, OUT_W'(0));
      check("rst_sof", OUT_W'(sof), OUT_W'(0));
      check("rst_eol", OUT_W'(eol), OUT_W'(0));

      // Eight strobes make exactly five words; check write latency on the first.
      vs_pulse(2'b00);
      step(1'b1, 1'b0, rnd());
      step(1'b1, 1'b0, rnd());
      check("t1_lat_hold", OUT_W'(den), OUT_W'(0));
      step(1'b1, 1'b0, rnd());
      check("t1_lat_den", OUT_W'(den), OUT_W'(1));
      check("t1_lat_cnt", OUT_W'(cnt), OUT_W'(1));
      repeat (5) step(1'b1, 1'b0, rnd());
      step(1'b0, 1'b0, '0);
      idle(2);
      check("t1_cnt", OUT_W'(cnt), OUT_W'(5));
      drain("t1");

      // Three strobes: second word carries 112 bits, zero-padded, with eol.
      rd_pct = 50;
      line(3);
      drain("t2");

      // Ramp mode.
      rd_pct = 0;
      vs_pulse(2'b01);
      line(2);
      idle(1);
      check("t3_w0", dout, 128'h06050403020109080706050403020100);
      check("t3_w0_sof", OUT_W'(sof), OUT_W'(1));
      rd_pct = 100;
      step(1'b0, 1'b0, '0);
      check("t3_w1", dout, 128'h0a090807);
      check("t3_w1_eol", OUT_W'(eol), OUT_W'(1));
      drain("t3");
      vs_pulse(2'b00);

      // Overflow with ovf_clr held: the last drop coincides with clear, so ovf must stay set.
      rd_pct = 0;
      ovf_clr = 1'b1;
      line(32);
      check("t4_cnt", OUT_W'(cnt), OUT_W'(16));
      check("t4_ovf_clr_vs_drop", OUT_W'(ovf), OUT_W'(1));
      step(1'b0, 1'b0, '0);
      ovf_clr = 1'b0;
      check("t4_ovf_cleared", OUT_W'(ovf), OUT_W'(0));
      rd_pct = 100;
      idle(16);
      check("t4_empty", OUT_W'(den), OUT_W'(0));
      exp_q.delete();

      // Full FIFO with a pop and a write in the same cycle.
      rd_pct = 0;
      line(26);
      check("t5_full", OUT_W'(cnt), OUT_W'(16));
      rd_pct = 100;
      step(1'b0, 1'b0, '0);
      rd_pct = 0;
      check("t5_cnt_kept", OUT_W'(cnt), OUT_W'(16));
      check("t5_no_ovf", OUT_W'(ovf), OUT_W'(0));
      drain("t5");

      // Random frames, modes and line lengths.
      rd_pct = 90;
      for (int f = 0; f < 4; f++) begin
         vs_pulse(2'($urandom_range(3)));
         for (int l = 0; l < 4; l++) begin
            line($urandom_range(1, 12));
            idle($urandom_range(0, 2));
         end
      end
      idle(5);
      check("rnd_no_ovf", OUT_W'(ovf), OUT_W'(0));
      drain("rnd");

      // Reset mid-line with three words queued.
      vs_pulse(2'b00);
      rd_pct = 0;
      repeat (6) step(1'b1, 1'b0, rnd());
      check("t6_queued", OUT_W'(cnt), OUT_W'(3));
      rst_n = 1'b0;
      step(1'b1, 1'b0, rnd());
      rst_n = 1'b1;
      check("t6_den", OUT_W'(den), OUT_W'(0));
      check("t6_cnt", OUT_W'(cnt), OUT_W'(0));
      check("t6_ovf", OUT_W'(ovf), OUT_W'(0));
      line(4);
      idle(2);
      check("t6_cnt_after", OUT_W'(cnt), OUT_W'(3));
      check("t6_sof_after_rst", OUT_W'(sof), OUT_W'(0));
      drain("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
